// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed driver for a bank of common-anode 7-segment digits. One
// digit is shown per dwell slot. The first BLANK_CYCLES clocks of every slot
// keep all enables inactive so the previous digit's segments can discharge.
// The following inputs are captured into shadow registers only at a frame
// boundary, so a frame never shows a mix of old and new values:
//   - digit nibbles
//   - per-digit scan mask
//   - brightness
// Brightness is applied by gating the enable with a free-running 4-bit PWM
// phase.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-low
//   digits_i     in   4*NUM_DIGITS nibbles; nibble k at [4k+3:4k], digit 0 leftmost
//   mask_i       in   NUM_DIGITS; 1 = digit scanned, 0 = skipped and never lit
//   bright_i     in   4-bit brightness, 0 = off .. 15 = full
//   seg_en_o     out  per-digit enable, polarity set by EN_ACTIVE_LOW
//   seg_data_o   out  nibble of the current slot's digit, to the hex decoder
//   active_idx_o out  index of the current slot's digit
//   frame_o      out  one-cycle pulse on the first cycle of a new frame
// ---------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int DWELL_CYCLES  = 100000,
    parameter int BLANK_CYCLES  = 500,
    parameter int EN_ACTIVE_LOW = 1,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     mask_i,
    input  logic [3:0]                bright_i,
    output logic [NUM_DIGITS-1:0]     seg_en_o,
    output logic [3:0]                seg_data_o,
    output logic [IDX_W-1:0]          active_idx_o,
    output logic                      frame_o
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);

    // Lowest set bit of m strictly above position cur.
    // MSB of the result flags whether such a bit exists.
    function automatic logic [IDX_W:0] next_higher(input logic [NUM_DIGITS-1:0] m,
                                                   input logic [IDX_W-1:0]      cur);
        logic [IDX_W:0] res;
        res = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (m[k] && (k > int'(cur))) begin
                res = {1'b1, IDX_W'(k)};
            end
        end
        return res;
    endfunction

    // Lowest set bit of m, or 0 when m is all zeros.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] m);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (m[k]) begin
                res = IDX_W'(k);
            end
        end
        return res;
    endfunction

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              r_pwm;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_mask;
    logic [3:0]              r_sh_bright;
    logic                    r_frame;

    logic [IDX_W:0]          w_next;
    logic                    w_wrap;
    logic                    w_boundary;
    logic [3:0]              w_nibble;
    logic                    w_mask_bit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_pwm_ok;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_en_hi;

    always_comb begin
        w_next     = next_higher(r_sh_mask, r_idx);
        w_wrap     = (r_cnt == LAST_CNT);
        // No higher scanned digit means this wrap ends the frame.
        // This also covers the all-masked case.
        w_boundary = w_wrap && !w_next[IDX_W];

        // Select by comparison rather than indexing.
        // This stays in range when NUM_DIGITS is not a power of two.
        w_nibble   = '0;
        w_mask_bit = 1'b0;
        w_onehot   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_nibble    = r_sh_digits[4*k +: 4];
                w_mask_bit  = r_sh_mask[k];
                w_onehot[k] = 1'b1;
            end
        end

        w_pwm_ok = (r_sh_bright == 4'hF) || (r_pwm < r_sh_bright);
        w_lit    = (r_cnt >= BLANK_CNT) && w_mask_bit && w_pwm_ok;
        w_en_hi  = w_lit ? w_onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pwm       <= '0;
            r_sh_digits <= '0;
            r_sh_mask   <= '1;
            r_sh_bright <= 4'hF;
            r_frame     <= 1'b0;
        end else begin
            r_pwm   <= r_pwm + 4'd1;
            r_frame <= w_boundary;
            if (w_wrap) begin
                r_cnt <= '0;
                if (w_boundary) begin
                    r_sh_digits <= digits_i;
                    r_sh_mask   <= mask_i;
                    r_sh_bright <= bright_i;
                    r_idx       <= lowest_set(mask_i);
                end else begin
                    r_idx <= w_next[IDX_W-1:0];
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign seg_en_o     = (EN_ACTIVE_LOW != 0) ? ~w_en_hi : w_en_hi;
    assign seg_data_o   = w_nibble;
    assign active_idx_o = r_idx;
    assign frame_o      = r_frame;

endmodule
